// File: rtl/pipe_skid_reg_pkg.sv
// ============================================================================
//  Module   : pipe_skid_reg_pkg
//  Purpose  : Shared widths, NOP/zero encodings, reset level and pointer-width
//             helper for the pipeline skid register slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_skid_reg_pkg;

    localparam int          C_INST_W    = 32;
    localparam int          C_PC_W      = 64;
    localparam logic [31:0] C_NOP       = 32'd0;
    localparam logic [63:0] C_ZERO64    = 64'd0;
    localparam logic        C_RST_LEVEL = 1'b1;

    // A single-entry ring still needs a 1-bit pointer to have a legal vector.
    function automatic int f_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ring_ptr.sv
// ============================================================================
//  Module   : pipe_ring_ptr
//  Purpose  : Wrap-around index into a DEPTH-entry ring; clr beats inc, and
//             the wrap is explicit so DEPTH need not be a power of two.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ring_ptr
    import pipe_skid_reg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = f_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst == C_RST_LEVEL) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
//  Module   : pipe_skid_reg
//  Purpose  : DEPTH-entry skid FIFO carrying {inst, pc, jump} between pipeline
//             stages with valid/ready handshake and synchronous flush.
//             Define YSYX_22051013_PIPE_PERF_EN to add stall/flush counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int INST_W = C_INST_W,
    parameter int PC_W   = C_PC_W,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_jump,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_jump,
    output logic [CNT_W-1:0]  count
`ifdef YSYX_22051013_PIPE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int               PTR_W   = f_ptr_w(DEPTH);
    localparam int               ENTRY_W = INST_W + PC_W + 1;
    localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);

    logic               w_rst;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    assign w_rst = (rst == C_RST_LEVEL);

    // Both handshake flags come straight off r_count, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (r_count != C_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    pipe_ring_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop),
        .clr (flush),
        .ptr (w_rd_ptr)
    );

    pipe_ring_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push),
        .clr (flush),
        .ptr (w_wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale slots are never visible because the
    // output mux is gated by out_valid and pointers restart at zero.
    always_ff @(posedge clk) begin
        if (!w_rst && !flush && w_push) begin
            r_mem[w_wr_ptr] <= {in_jump, in_pc, in_inst};
        end
    end

    assign w_head   = r_mem[w_rd_ptr];
    assign out_inst = out_valid ? w_head[INST_W-1:0]         : INST_W'(C_NOP);
    assign out_pc   = out_valid ? w_head[INST_W +: PC_W]     : PC_W'(C_ZERO64);
    assign out_jump = out_valid ? w_head[ENTRY_W-1]          : 1'b0;
    assign count    = r_count;

`ifdef YSYX_22051013_PIPE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Flush does not clear these; only reset does.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush && (r_count != '0)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
//  Module   : tb_pipe_skid_reg
//  Purpose  : Self-checking bench for pipe_skid_reg (DEPTH=2 and DEPTH=3)
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        jump;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_jump, a_flush;
    logic [31:0] a_in_inst, a_out_inst;
    logic [63:0] a_in_pc, a_out_pc;
    logic        a_out_valid, a_out_ready, a_out_jump;
    logic [1:0]  a_count;

    logic        b_in_valid, b_in_ready, b_in_jump, b_flush;
    logic [31:0] b_in_inst, b_out_inst;
    logic [63:0] b_in_pc, b_out_pc;
    logic        b_out_valid, b_out_ready, b_out_jump;
    logic [1:0]  b_count;

`ifdef YSYX_22051013_PIPE_PERF_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    pipe_skid_reg u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_inst   (a_in_inst),
        .in_pc     (a_in_pc),
        .in_jump   (a_in_jump),
        .flush     (a_flush),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_inst  (a_out_inst),
        .out_pc    (a_out_pc),
        .out_jump  (a_out_jump),
        .count     (a_count)
`ifdef YSYX_22051013_PIPE_PERF_EN
        ,
        .stall_cnt (a_stall_cnt),
        .flush_cnt (a_flush_cnt)
`endif
    );

    pipe_skid_reg #(.DEPTH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_inst   (b_in_inst),
        .in_pc     (b_in_pc),
        .in_jump   (b_in_jump),
        .flush     (b_flush),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_inst  (b_out_inst),
        .out_pc    (b_out_pc),
        .out_jump  (b_out_jump),
        .count     (b_count)
`ifdef YSYX_22051013_PIPE_PERF_EN
        ,
        .stall_cnt (b_stall_cnt),
        .flush_cnt (b_flush_cnt)
`endif
    );

    ent_t qa[$];
    ent_t qb[$];
    ent_t b_in_log[$];
    ent_t b_out_log[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    // Reference: a bounded queue; flush/reset empty it, pop precedes push
    // and a push is accepted only if the queue was not full at the edge.
    task automatic tick();
        int na;
        int nb;
        @(posedge clk);
        na = qa.size();
        nb = qb.size();
        if (rst) begin
            qa.delete();
            qb.delete();
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (a_in_valid && na == 2) exp_stall++;
            if (a_flush && na != 0)    exp_flush++;
            if (a_flush) begin
                qa.delete();
            end else begin
                if (na != 0 && a_out_ready) void'(qa.pop_front());
                if (a_in_valid && na != 2) qa.push_back({a_in_inst, a_in_pc, a_in_jump});
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (nb != 0 && b_out_ready) void'(qb.pop_front());
                if (b_in_valid && nb != 3) begin
                    qb.push_back({b_in_inst, b_in_pc, b_in_jump});
                    b_in_log.push_back({b_in_inst, b_in_pc, b_in_jump});
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [100:0] vec_a();
        ent_t h = (qa.size() != 0) ? qa[0] : '0;
        return {qa.size() != 0, qa.size() != 2, 2'(qa.size()), h.inst, h.pc, h.jump};
    endfunction

    function automatic logic [100:0] vec_b();
        ent_t h = (qb.size() != 0) ? qb[0] : '0;
        return {qb.size() != 0, qb.size() != 3, 2'(qb.size()), h.inst, h.pc, h.jump};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++;
        if (a_out_pc !== 64'd0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", a_out_pc); end
        checks++;
        if (a_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        checks++;
        if ({a_out_inst, a_out_jump} !== 33'd0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", a_out_inst); end
        checks++;
        if ({b_in_ready, b_out_valid, b_count} !== 4'b1000) begin
            failures++; $display("FAIL reset_dut3 got=%b exp=1000", {b_in_ready, b_out_valid, b_count});
        end
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_pc    = 64'h8000_0000 + 64'(4 * i);
            a_in_inst  = $urandom;
            a_in_jump  = 1'(i);
            tick();
            checks++;
            if (a_out_pc !== 64'h8000_0000 + 64'(4 * i)) begin
                failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, a_out_pc, 64'h8000_0000 + 64'(4 * i));
            end
            checks++;
            if ({a_count, a_in_ready, a_out_valid} !== 4'b0111) begin
                failures++; $display("FAIL b2b_flags[%0d] got=%b exp=0111", i, {a_count, a_in_ready, a_out_valid});
            end
            checks++;
            if ({a_out_valid, a_in_ready, a_count, a_out_inst, a_out_pc, a_out_jump} !== vec_a()) begin
                failures++; $display("FAIL b2b_model[%0d] got=%h exp=%h", i,
                    {a_out_valid, a_in_ready, a_count, a_out_inst, a_out_pc, a_out_jump}, vec_a());
            end
        end
        a_in_valid = 1'b0;
        tick();
        checks++;
        if ({a_out_valid, a_count, a_out_pc} !== 67'd0) begin
            failures++; $display("FAIL b2b_drain got=%b/%0d/%h exp=0/0/0", a_out_valid, a_count, a_out_pc);
        end
    endtask

    task automatic test_full_stall();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_pc    = 64'h8000_0000 + 64'(4 * i);
            a_in_inst  = $urandom;
            a_in_jump  = 1'b0;
            tick();
        end
        checks++;
        if ({a_count, a_in_ready, a_out_pc} !== {2'd2, 1'b0, 64'h8000_0000}) begin
            failures++; $display("FAIL full_hold got=%0d/%b/%h exp=2/0/80000000", a_count, a_in_ready, a_out_pc);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if ({a_count, a_in_ready, a_out_pc} !== {2'd1, 1'b1, 64'h8000_0004}) begin
            failures++; $display("FAIL full_pop got=%0d/%b/%h exp=1/1/80000004", a_count, a_in_ready, a_out_pc);
        end
        a_out_ready = 1'b0;
        tick();
        a_in_valid = 1'b0;
        checks++;
        if ({a_count, a_out_pc} !== {2'd2, 64'h8000_0004}) begin
            failures++; $display("FAIL full_refill got=%0d/%h exp=2/80000004", a_count, a_out_pc);
        end
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_out_valid, a_in_ready, a_count, a_out_inst, a_out_pc, a_out_jump} !== vec_a()) begin
                failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i,
                    {a_out_valid, a_in_ready, a_count, a_out_inst, a_out_pc, a_out_jump}, vec_a());
            end
        end
    endtask

    task automatic test_flush();
        bit seen;
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1;
            a_in_pc    = 64'h1000 + 64'(4 * i);
            a_in_inst  = 32'h1111_0000 + 32'(i);
            a_in_jump  = 1'b1;
            tick();
        end
        a_flush   = 1'b1;
        a_in_pc   = 64'hDEAD_0000;
        a_in_inst = 32'hDEAD_BEEF;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        checks++;
        if ({a_count, a_out_valid, a_out_inst, a_in_ready} !== {2'd0, 1'b0, 32'd0, 1'b1}) begin
            failures++; $display("FAIL flush_clear got=%0d/%b/%h/%b exp=0/0/0/1",
                a_count, a_out_valid, a_out_inst, a_in_ready);
        end
        a_out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_out_valid && a_out_pc == 64'hDEAD_0000) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL flush_dropped_push got=emitted exp=never"); end
    endtask

    task automatic test_perf();
`ifdef YSYX_22051013_PIPE_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        a_in_valid = 1'b0;
        checks++;
        if (a_stall_cnt !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", a_stall_cnt); end
        a_flush = 1'b1;
        tick();
        tick();
        a_flush = 1'b0;
        checks++;
        if (a_flush_cnt !== 32'd1) begin failures++; $display("FAIL perf_flush got=%0d exp=1", a_flush_cnt); end
        checks++;
        if ({a_stall_cnt, a_flush_cnt} !== {32'(exp_stall), 32'(exp_flush)}) begin
            failures++; $display("FAIL perf_model got=%0d/%0d exp=%0d/%0d", a_stall_cnt, a_flush_cnt, exp_stall, exp_flush);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a_stall_cnt, a_flush_cnt} !== 64'd0) begin
            failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", a_stall_cnt, a_flush_cnt);
        end
`endif
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        b_in_log.delete();
        b_out_log.delete();
        while (b_out_log.size() < 10 && cyc < 400) begin
            checks++;
            if ({b_out_valid, b_in_ready, b_count, b_out_inst, b_out_pc, b_out_jump} !== vec_b()) begin
                failures++; $display("FAIL wrap_model[%0d] got=%h exp=%h", cyc,
                    {b_out_valid, b_in_ready, b_count, b_out_inst, b_out_pc, b_out_jump}, vec_b());
            end
            checks++;
            if (b_count > 2'd3 || b_count === 2'bxx) begin failures++; $display("FAIL wrap_count got=%0d exp<=3", b_count); end
            b_in_valid  = (sent < 10) && ($urandom_range(0, 3) != 0);
            b_in_inst   = $urandom;
            b_in_pc     = {$urandom, $urandom};
            b_in_jump   = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 2) != 0);
            if (b_out_valid && b_out_ready) b_out_log.push_back({b_out_inst, b_out_pc, b_out_jump});
            if (b_in_valid && b_in_ready) sent++;
            tick();
            cyc++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        checks++;
        if (b_out_log.size() != 10) begin failures++; $display("FAIL wrap_timeout got=%0d exp=10", b_out_log.size()); end
        for (int i = 0; i < 10 && i < b_out_log.size() && i < b_in_log.size(); i++) begin
            checks++;
            if (b_out_log[i] !== b_in_log[i]) begin
                failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, b_out_log[i], b_in_log[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            checks++;
            if ({a_out_valid, a_in_ready, a_count, a_out_inst, a_out_pc, a_out_jump} !== vec_a()) begin
                failures++; $display("FAIL rand_model[%0d] got=%h exp=%h", i,
                    {a_out_valid, a_in_ready, a_count, a_out_inst, a_out_pc, a_out_jump}, vec_a());
            end
`ifdef YSYX_22051013_PIPE_PERF_EN
            checks++;
            if ({a_stall_cnt, a_flush_cnt} !== {32'(exp_stall), 32'(exp_flush)}) begin
                failures++; $display("FAIL rand_perf[%0d] got=%0d/%0d exp=%0d/%0d", i,
                    a_stall_cnt, a_flush_cnt, exp_stall, exp_flush);
            end
`endif
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_inst   = $urandom;
            a_in_pc     = {$urandom, $urandom};
            a_in_jump   = 1'($urandom_range(0, 1));
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        a_in_valid = 1'b0;
        a_flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {a_in_valid, a_in_jump, a_flush, a_out_ready} = '0;
        {b_in_valid, b_in_jump, b_flush, b_out_ready} = '0;
        a_in_inst = '0; a_in_pc = '0;
        b_in_inst = '0; b_in_pc = '0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_flush();
        test_perf();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
